msg_load_ctrl: RTL

//  Sequencer for the SHA-256 message path. On a go pulse it streams the message bytes from

---
 rtl/msg_load_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/msg_load_ctrl.sv
// msg_load_ctrl: streams a single-block SHA-256 message from SRAM into the block
// assembler one byte per cycle, starts the hash core, then pulses finish on completion.
module msg_load_ctrl #(
  parameter  int MAX_MESSAGE_LENGTH = 55,
  parameter  int ADDR_W             = 16,
  localparam int LW                 = $clog2(MAX_MESSAGE_LENGTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              xxx__dut__go,
  input  logic [LW-1:0]     xxx__dut__msg_length,
  output logic [ADDR_W-1:0] dut__msg__address,
  output logic              dut__msg__enable,
  output logic              core_start,
  input  logic              core_done,
  output logic              dut__xxx__busy,
  output logic              dut__xxx__finish
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [LW-1:0] MAX_LEN  = LW'(MAX_MESSAGE_LENGTH);
  localparam logic [LW-1:0] CNT_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] CNT_ONE  = {{(LW-1){1'b0}}, 1'b1};

  state_t      state_r;
  state_t      state_s;
  logic [LW-1:0] cnt_r;
  logic [LW-1:0] cnt_s;
  logic [LW-1:0] len_r;
  logic [LW-1:0] len_s;
  logic [LW-1:0] len_clamp_s;

  // Clamp the requested length to what fits in one 512-bit block
  always_comb begin
    if (xxx__dut__msg_length > MAX_LEN) begin
      len_clamp_s = MAX_LEN;
    end else begin
      len_clamp_s = xxx__dut__msg_length;
    end
  end

  // Next-state, byte counter and length capture
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    len_s   = len_r;
    case (state_r)
      ST_IDLE: begin
        if (xxx__dut__go) begin
          len_s = len_clamp_s;
          cnt_s = CNT_ZERO;
          // An empty message skips the SRAM entirely; the assembler still pads
          if (len_clamp_s != CNT_ZERO) begin
            state_s = ST_READ;
          end else begin
            state_s = ST_SETTLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cnt_r == (len_r - CNT_ONE)) begin
          state_s = ST_SETTLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = ST_READ;
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      ST_SETTLE: begin
        state_s = ST_START;
      end
      ST_START: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and captured length registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      len_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      len_r   <= len_s;
    end
  end

  // Outputs registered from the next state so they line up with the state they decode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dut__msg__address <= {ADDR_W{1'b0}};
      dut__msg__enable  <= 1'b0;
      core_start        <= 1'b0;
      dut__xxx__busy    <= 1'b0;
      dut__xxx__finish  <= 1'b0;
    end else begin
      dut__msg__address <= (state_s == ST_READ) ? ADDR_W'(cnt_s) : {ADDR_W{1'b0}};
      dut__msg__enable  <= (state_s == ST_READ);
      core_start        <= (state_s == ST_START);
      dut__xxx__busy    <= (state_s != ST_IDLE);
      dut__xxx__finish  <= (state_s == ST_FIN);
    end
  end

endmodule
